// File: rtl/uart_core.sv
// UART 8N1 transmit/receive engine sitting behind the UART CSR block.
// The divisor is derived from br/clk_mhz and latched by each FSM as it leaves IDLE.
module uart_core #(
  parameter int SYNC_STAGES = 2,
  parameter int MIN_DIV     = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       strtx,
  input  logic [3:0] br,
  input  logic [7:0] clk_mhz,
  input  logic [7:0] tx_data,
  output logic       tx_busy,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  input  logic       rx_ack,
  output logic       rx_frame_err,
  output logic       rx_overrun,
  input  logic       uart_rxd,
  output logic       uart_txd
);

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;

  // Divisor: (clk_mhz * MULT[br]) >> 4, clamped from below.
  logic [10:0] mult;
  logic [19:0] prod;
  logic [15:0] div_raw;
  logic [15:0] div;

  always_comb begin
    mult = 11'd139;
    case (br)
      4'd0:    mult = 11'd1667;
      4'd1:    mult = 11'd833;
      4'd2:    mult = 11'd417;
      4'd3:    mult = 11'd278;
      4'd4:    mult = 11'd139;
      4'd5:    mult = 11'd69;
      4'd6:    mult = 11'd35;
      4'd7:    mult = 11'd17;
      default: mult = 11'd139;
    endcase
  end

  assign prod    = 20'(clk_mhz) * 20'(mult);
  assign div_raw = prod[19:4];
  assign div     = (div_raw < 16'(MIN_DIV)) ? 16'(MIN_DIV) : div_raw;

  // ---------------- transmitter ----------------
  state_t      tx_state, tx_state_n;
  logic [15:0] tx_cnt, tx_cnt_n, tx_div, tx_div_n;
  logic [2:0]  tx_bit, tx_bit_n;
  logic [7:0]  tx_shift, tx_shift_n;
  logic        strtx_d;
  logic        tx_last;

  assign tx_last = (tx_cnt == tx_div - 16'd1);

  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt;
    tx_div_n   = tx_div;
    tx_bit_n   = tx_bit;
    tx_shift_n = tx_shift;
    case (tx_state)
      ST_IDLE: begin
        if (strtx && !strtx_d) begin
          tx_state_n = ST_START;
          tx_shift_n = tx_data;
          tx_div_n   = div;
          tx_cnt_n   = 16'd0;
        end
      end
      ST_START: begin
        tx_cnt_n = tx_cnt + 16'd1;
        if (tx_last) begin
          tx_cnt_n   = 16'd0;
          tx_bit_n   = 3'd0;
          tx_state_n = ST_DATA;
        end
      end
      ST_DATA: begin
        tx_cnt_n = tx_cnt + 16'd1;
        if (tx_last) begin
          tx_cnt_n   = 16'd0;
          tx_shift_n = {1'b0, tx_shift[7:1]};
          tx_bit_n   = tx_bit + 3'd1;
          if (tx_bit == 3'd7) tx_state_n = ST_STOP;
        end
      end
      ST_STOP: begin
        tx_cnt_n = tx_cnt + 16'd1;
        if (tx_last) tx_state_n = ST_IDLE;
      end
      default: tx_state_n = ST_IDLE;
    endcase
    if (!en) tx_state_n = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state <= ST_IDLE;
      tx_cnt   <= 16'd0;
      tx_div   <= 16'd0;
      tx_bit   <= 3'd0;
      tx_shift <= 8'h00;
      strtx_d  <= 1'b0;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_div   <= tx_div_n;
      tx_bit   <= tx_bit_n;
      tx_shift <= tx_shift_n;
      strtx_d  <= strtx;
    end
  end

  always_comb begin
    tx_busy  = en && (tx_state != ST_IDLE);
    uart_txd = 1'b1;
    if (en) begin
      case (tx_state)
        ST_START: uart_txd = 1'b0;
        ST_DATA:  uart_txd = tx_shift[0];
        default:  uart_txd = 1'b1;
      endcase
    end
  end

  // ---------------- receiver ----------------
  // rx_valid/rx_ack: rx_valid holds until a one-cycle rx_ack; a store in the
  // same cycle as rx_ack takes priority and leaves rx_valid set.
  logic [SYNC_STAGES-1:0] rx_sync;
  logic                   rxs;
  state_t      rx_state, rx_state_n;
  logic [15:0] rx_cnt, rx_cnt_n, rx_div, rx_div_n;
  logic [2:0]  rx_bit, rx_bit_n;
  logic [7:0]  rx_shift, rx_shift_n;
  logic [7:0]  rx_data_n;
  logic        rx_valid_n, rx_fe_n, rx_ovr_n;

  assign rxs = rx_sync[SYNC_STAGES-1];

  always_comb begin
    rx_state_n = rx_state;
    rx_cnt_n   = rx_cnt;
    rx_div_n   = rx_div;
    rx_bit_n   = rx_bit;
    rx_shift_n = rx_shift;
    rx_data_n  = rx_data;
    rx_valid_n = rx_valid && !rx_ack;
    rx_fe_n    = 1'b0;
    rx_ovr_n   = 1'b0;
    case (rx_state)
      ST_IDLE: begin
        if (!rxs) begin
          rx_state_n = ST_START;
          rx_div_n   = div;
          rx_cnt_n   = {1'b0, div[15:1]};
        end
      end
      ST_START: begin
        rx_cnt_n = rx_cnt - 16'd1;
        if (rx_cnt == 16'd0) begin
          rx_cnt_n   = rx_div - 16'd1;
          rx_bit_n   = 3'd0;
          rx_state_n = rxs ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        rx_cnt_n = rx_cnt - 16'd1;
        if (rx_cnt == 16'd0) begin
          rx_cnt_n   = rx_div - 16'd1;
          rx_shift_n = {rxs, rx_shift[7:1]};
          rx_bit_n   = rx_bit + 3'd1;
          if (rx_bit == 3'd7) rx_state_n = ST_STOP;
        end
      end
      ST_STOP: begin
        rx_cnt_n = rx_cnt - 16'd1;
        if (rx_cnt == 16'd0) begin
          // Leave at mid-stop so an immediately following start bit is seen.
          rx_state_n = ST_IDLE;
          if (rxs) begin
            rx_data_n  = rx_shift;
            rx_valid_n = 1'b1;
            rx_ovr_n   = rx_valid;
          end else begin
            rx_fe_n = 1'b1;
          end
        end
      end
      default: rx_state_n = ST_IDLE;
    endcase
    if (!en) begin
      rx_state_n = ST_IDLE;
      rx_valid_n = 1'b0;
      rx_fe_n    = 1'b0;
      rx_ovr_n   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_sync      <= '1;
      rx_state     <= ST_IDLE;
      rx_cnt       <= 16'd0;
      rx_div       <= 16'd0;
      rx_bit       <= 3'd0;
      rx_shift     <= 8'h00;
      rx_data      <= 8'h00;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
      rx_overrun   <= 1'b0;
    end else begin
      rx_sync      <= {rx_sync[SYNC_STAGES-2:0], uart_rxd};
      rx_state     <= rx_state_n;
      rx_cnt       <= rx_cnt_n;
      rx_div       <= rx_div_n;
      rx_bit       <= rx_bit_n;
      rx_shift     <= rx_shift_n;
      rx_data      <= rx_data_n;
      rx_valid     <= rx_valid_n;
      rx_frame_err <= rx_fe_n;
      rx_overrun   <= rx_ovr_n;
    end
  end

endmodule

// File: tb/tb_uart_core.sv
// Directed bench for uart_core: TX framing/timing, loopback RX, overrun,
// frame error, glitch rejection, enable abort and ack/store collision.
module tb_uart_core;

  logic       clk = 1'b0;
  logic       rst, en, strtx, rx_ack;
  logic [3:0] br;
  logic [7:0] clk_mhz, tx_data;
  logic       tx_busy, rx_valid, rx_frame_err, rx_overrun, uart_txd;
  logic [7:0] rx_data;
  logic       uart_rxd, rxd_drv, loop_en;

  int n_cmp  = 0;
  int n_fail = 0;
  int fe_cnt = 0;
  int ovr_cnt = 0;

  assign uart_rxd = loop_en ? uart_txd : rxd_drv;

  uart_core #(.SYNC_STAGES(2), .MIN_DIV(16)) dut (
    .clk(clk), .rst(rst), .en(en), .strtx(strtx), .br(br), .clk_mhz(clk_mhz),
    .tx_data(tx_data), .tx_busy(tx_busy), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ack(rx_ack), .rx_frame_err(rx_frame_err), .rx_overrun(rx_overrun),
    .uart_rxd(uart_rxd), .uart_txd(uart_txd)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rx_frame_err) fe_cnt <= fe_cnt + 1;
    if (rx_overrun)   ovr_cnt <= ovr_cnt + 1;
  end

  task automatic wait_cycle();
    @(posedge clk);
    #1;
  endtask

  // Drive one serial frame on rxd_drv; rx_ack is raised in iteration ack_k.
  task automatic send_rx(input logic [7:0] b, input logic stop, input int dv, input int ack_k);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int k = 0; k < 10 * dv; k++) begin
      wait_cycle();
      rxd_drv = fr[k / dv];
      rx_ack  = (k == ack_k);
    end
    wait_cycle();
    rx_ack  = 1'b0;
    rxd_drv = 1'b1;
  endtask

  // Start a TX frame and check every bit at mid-bit plus the busy length.
  task automatic run_tx(input string nm, input logic [7:0] b, input int dv, input logic retrig);
    logic [9:0] fr;
    int busy;
    fr = {1'b1, b, 1'b0};
    strtx = 1'b0;
    wait_cycle();
    tx_data = b;
    strtx = 1'b1;
    wait_cycle();
    busy = 0;
    for (int k = 0; k < 20 * dv; k++) begin
      if (!tx_busy) break;
      busy++;
      if ((k % dv) == (dv / 2) && (k / dv) < 10) begin
        n_cmp++;
        if (uart_txd !== fr[k / dv]) begin
          n_fail++;
          $display("FAIL %s bit%0d: txd=%b expected %b", nm, k / dv, uart_txd, fr[k / dv]);
        end
      end
      if (retrig && k == 100) strtx = 1'b0;
      if (retrig && k == 101) begin
        strtx = 1'b1;
        tx_data = ~b;
      end
      wait_cycle();
    end
    n_cmp++;
    if (busy !== 10 * dv) begin
      n_fail++;
      $display("FAIL %s busy_len: got %0d expected %0d", nm, busy, 10 * dv);
    end
    strtx = 1'b0;
  endtask

  task automatic ack_pulse();
    rx_ack = 1'b1;
    wait_cycle();
    rx_ack = 1'b0;
    wait_cycle();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) wait_cycle();
    n_cmp += 6;
    if (uart_txd !== 1'b1)     begin n_fail++; $display("FAIL reset txd: got %b expected 1", uart_txd); end
    if (tx_busy !== 1'b0)      begin n_fail++; $display("FAIL reset tx_busy: got %b expected 0", tx_busy); end
    if (rx_valid !== 1'b0)     begin n_fail++; $display("FAIL reset rx_valid: got %b expected 0", rx_valid); end
    if (rx_data !== 8'h00)     begin n_fail++; $display("FAIL reset rx_data: got %h expected 00", rx_data); end
    if (rx_frame_err !== 1'b0) begin n_fail++; $display("FAIL reset frame_err: got %b expected 0", rx_frame_err); end
    if (rx_overrun !== 1'b0)   begin n_fail++; $display("FAIL reset overrun: got %b expected 0", rx_overrun); end
    rst = 1'b0;
    wait_cycle();
  endtask

  task automatic test_tx_pattern();
    clk_mhz = 8'd10;
    br = 4'hf;
    run_tx("tx_a5", 8'hA5, 86, 1'b0);
  endtask

  task automatic test_loopback();
    int t;
    loop_en = 1'b1;
    clk_mhz = 8'd50;
    br = 4'd0;
    strtx = 1'b0;
    wait_cycle();
    tx_data = 8'h3C;
    strtx = 1'b1;
    t = 0;
    while (!rx_valid && t < 60000) begin
      wait_cycle();
      t++;
    end
    n_cmp += 2;
    if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL loop_valid: timeout rx_valid=%b expected 1", rx_valid); end
    if (rx_data !== 8'h3C) begin n_fail++; $display("FAIL loop_data: got %h expected 3c", rx_data); end
    rx_ack = 1'b1;
    wait_cycle();
    rx_ack = 1'b0;
    n_cmp++;
    if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL loop_ack: rx_valid=%b expected 0", rx_valid); end
    t = 0;
    while (tx_busy && t < 10000) begin
      wait_cycle();
      t++;
    end
    strtx = 1'b0;
    repeat (10) wait_cycle();
  endtask

  task automatic test_back_to_back_retrigger();
    clk_mhz = 8'd0;
    run_tx("tx_retrig", 8'h96, 16, 1'b1);
    repeat (20) wait_cycle();
    n_cmp++;
    if (rx_data !== 8'h96) begin n_fail++; $display("FAIL retrig_rx_data: got %h expected 96", rx_data); end
    loop_en = 1'b0;
    rxd_drv = 1'b1;
    ack_pulse();
  endtask

  task automatic test_overrun_frame_err();
    int o0, f0;
    clk_mhz = 8'd0;
    o0 = ovr_cnt;
    send_rx(8'h11, 1'b1, 16, -1);
    send_rx(8'h22, 1'b1, 16, -1);
    repeat (20) wait_cycle();
    n_cmp += 3;
    if (ovr_cnt - o0 !== 1)  begin n_fail++; $display("FAIL overrun_cnt: got %0d expected 1", ovr_cnt - o0); end
    if (rx_data !== 8'h22)   begin n_fail++; $display("FAIL overrun_data: got %h expected 22", rx_data); end
    if (rx_valid !== 1'b1)   begin n_fail++; $display("FAIL overrun_valid: got %b expected 1", rx_valid); end
    f0 = fe_cnt;
    o0 = ovr_cnt;
    send_rx(8'h55, 1'b0, 16, -1);
    repeat (40) wait_cycle();
    n_cmp += 4;
    if (fe_cnt - f0 !== 1)   begin n_fail++; $display("FAIL fe_cnt: got %0d expected 1", fe_cnt - f0); end
    if (rx_data !== 8'h22)   begin n_fail++; $display("FAIL fe_data: got %h expected 22", rx_data); end
    if (rx_valid !== 1'b1)   begin n_fail++; $display("FAIL fe_valid: got %b expected 1", rx_valid); end
    if (ovr_cnt - o0 !== 0)  begin n_fail++; $display("FAIL fe_overrun: got %0d expected 0", ovr_cnt - o0); end
  endtask

  task automatic test_glitch();
    int f0;
    clk_mhz = 8'd10;
    br = 4'hf;
    ack_pulse();
    f0 = fe_cnt;
    rxd_drv = 1'b0;
    repeat (20) wait_cycle();
    rxd_drv = 1'b1;
    repeat (200) wait_cycle();
    n_cmp += 2;
    if (rx_valid !== 1'b0)  begin n_fail++; $display("FAIL glitch_valid: got %b expected 0", rx_valid); end
    if (fe_cnt - f0 !== 0)  begin n_fail++; $display("FAIL glitch_fe: got %0d expected 0", fe_cnt - f0); end
    send_rx(8'hC3, 1'b1, 86, -1);
    repeat (20) wait_cycle();
    n_cmp += 2;
    if (rx_valid !== 1'b1)  begin n_fail++; $display("FAIL post_glitch_valid: got %b expected 1", rx_valid); end
    if (rx_data !== 8'hC3)  begin n_fail++; $display("FAIL post_glitch_data: got %h expected c3", rx_data); end
  endtask

  task automatic test_en_drop();
    clk_mhz = 8'd0;
    strtx = 1'b0;
    wait_cycle();
    tx_data = 8'h00;
    strtx = 1'b1;
    wait_cycle();
    repeat (50) wait_cycle();
    n_cmp++;
    if (tx_busy !== 1'b1) begin n_fail++; $display("FAIL en_pre_busy: got %b expected 1", tx_busy); end
    en = 1'b0;
    wait_cycle();
    n_cmp += 3;
    if (uart_txd !== 1'b1) begin n_fail++; $display("FAIL en_drop_txd: got %b expected 1", uart_txd); end
    if (tx_busy !== 1'b0)  begin n_fail++; $display("FAIL en_drop_busy: got %b expected 0", tx_busy); end
    if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL en_drop_valid: got %b expected 0", rx_valid); end
    en = 1'b1;
    strtx = 1'b0;
    repeat (5) wait_cycle();
    n_cmp++;
    if (tx_busy !== 1'b0)  begin n_fail++; $display("FAIL en_restore_busy: got %b expected 0", tx_busy); end
  endtask

  task automatic test_ack_collision();
    clk_mhz = 8'd0;
    // Store lands on the 156th edge after the start bit is driven at div=16.
    send_rx(8'hA6, 1'b1, 16, 155);
    repeat (3) wait_cycle();
    n_cmp += 2;
    if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL collide_valid: got %b expected 1", rx_valid); end
    if (rx_data !== 8'hA6) begin n_fail++; $display("FAIL collide_data: got %h expected a6", rx_data); end
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; strtx = 1'b0; rx_ack = 1'b0;
    br = 4'hf; clk_mhz = 8'd10; tx_data = 8'h00;
    loop_en = 1'b0; rxd_drv = 1'b1;
    test_reset();
    test_tx_pattern();
    test_loopback();
    test_back_to_back_retrigger();
    test_overrun_frame_err();
    test_glitch();
    test_en_drop();
    test_ack_collision();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
